// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 1101 match reporter slice.
// SEQ_MATCH_REPORTER_TIMESTAMP_EN adds a 32-bit timestamp field to the report.
package seq_det_pkg;

  localparam int DEF_FRAME_LEN = 16;
  localparam int DEF_CNT_W     = 4;
  localparam int DEF_POS_W     = $clog2(DEF_FRAME_LEN);

  typedef enum logic {IDLE, RUN} rep_state_e;

  // Report field widths follow the package defaults; raise these together with the top's parameters.
  typedef struct packed {
    logic [DEF_CNT_W-1:0] count;
    logic [DEF_POS_W-1:0] first;
    logic [DEF_POS_W-1:0] last;
    logic                 none;
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
    logic [31:0]          ts;
`endif
  } report_t;

endpackage

// File: rtl/seq_frame_ctr.sv
// Bit-index counter for one frame: advances on each processed bit and wraps after FRAME_LEN bits.
module seq_frame_ctr #(
  parameter int FRAME_LEN = 16,
  parameter int POS_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [POS_W-1:0] idx,
  output logic             last_bit,
  output logic             wrap
);

  assign last_bit = (idx == POS_W'(FRAME_LEN - 1));
  assign wrap     = en & last_bit;

  // clear wins over en so a discarded frame always restarts at index 0
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      idx <= '0;
    end else if (en) begin
      idx <= last_bit ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/seq_match_reporter.sv
// Per-frame match reporter behind the 1101 detector, with a valid/ready report port.
// Define SEQ_MATCH_REPORTER_TIMESTAMP_EN to add a free-running cycle stamp (rpt_ts) to each report.
module seq_match_reporter
  import seq_det_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int POS_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             bit_valid,
  input  logic             det,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic [POS_W-1:0] rpt_first,
  output logic [POS_W-1:0] rpt_last,
  output logic             rpt_none,
  output logic             overrun
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
  ,output logic [31:0]     rpt_ts
`endif
);

  rep_state_e       state;
  logic [POS_W-1:0] idx;
  logic             last_bit;
  logic             wrap;
  logic             running;
  logic             step;
  logic             hit;
  logic             accept;
  logic [CNT_W-1:0] acc_count;
  logic [POS_W-1:0] acc_first;
  logic [POS_W-1:0] acc_last;
  logic [CNT_W-1:0] count_next;
  logic [POS_W-1:0] first_next;
  logic [POS_W-1:0] last_next;
  report_t          rpt_q;
  logic             rpt_valid_q;
  logic             overrun_q;

  assign running = (state == RUN) && en;
  assign step    = running && bit_valid;
  assign hit     = step && det;
  assign accept  = rpt_valid_q && rpt_ready;

  seq_frame_ctr #(
    .FRAME_LEN(FRAME_LEN),
    .POS_W    (POS_W)
  ) u_frame_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (!running),
    .en      (step),
    .idx     (idx),
    .last_bit(last_bit),
    .wrap    (wrap)
  );

  // A zero count doubles as "no match yet", since a saturating count never returns to zero.
  always_comb begin
    count_next = acc_count;
    first_next = acc_first;
    last_next  = acc_last;
    if (hit) begin
      if (acc_count != '1) begin
        count_next = acc_count + 1'b1;
      end
      if (acc_count == '0) begin
        first_next = idx;
      end
      last_next = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc_count <= '0;
      acc_first <= '0;
      acc_last  <= '0;
    end else begin
      case (state)
        IDLE:    if (en)  state <= RUN;
        RUN:     if (!en) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (!running || (step && last_bit)) begin
        acc_count <= '0;
        acc_first <= '0;
        acc_last  <= '0;
      end else if (step) begin
        acc_count <= count_next;
        acc_first <= first_next;
        acc_last  <= last_next;
      end
    end
  end

`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
  logic [31:0] ts_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ts_cnt <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
    end
  end
`endif

  // A closing frame may take the slot only if it is empty or being handed off this very cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      rpt_q       <= '0;
      rpt_q.none  <= 1'b1;
    end else if (wrap) begin
      if (!rpt_valid_q || accept) begin
        rpt_valid_q <= 1'b1;
        rpt_q.count <= DEF_CNT_W'(count_next);
        rpt_q.first <= DEF_POS_W'(first_next);
        rpt_q.last  <= DEF_POS_W'(last_next);
        rpt_q.none  <= (count_next == '0);
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
        rpt_q.ts    <= ts_cnt;
`endif
      end else begin
        overrun_q <= 1'b1;
      end
    end else if (accept) begin
      rpt_valid_q <= 1'b0;
    end
  end

  assign rpt_valid = rpt_valid_q;
  assign overrun   = overrun_q;
  assign rpt_count = CNT_W'(rpt_q.count);
  assign rpt_first = POS_W'(rpt_q.first);
  assign rpt_last  = POS_W'(rpt_q.last);
  assign rpt_none  = rpt_q.none;
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
  assign rpt_ts    = rpt_q.ts;
`endif

endmodule

// File: tb/tb_seq_match_reporter.sv
// Directed bench for seq_match_reporter with a frame-level reference model checked every cycle.
// When SEQ_MATCH_REPORTER_TIMESTAMP_EN is defined the report timestamp is checked as well.
`timescale 1ns/1ps
module tb_seq_match_reporter;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;
  localparam int POS_W     = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             en        = 1'b0;
  logic             bit_valid = 1'b0;
  logic             det       = 1'b0;
  logic             rpt_ready = 1'b0;
  logic             rpt_valid;
  logic [CNT_W-1:0] rpt_count;
  logic [POS_W-1:0] rpt_first;
  logic [POS_W-1:0] rpt_last;
  logic             rpt_none;
  logic             overrun;
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
  logic [31:0]      rpt_ts;
`endif

  int total  = 0;
  int bad    = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  seq_match_reporter #(
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W),
    .POS_W    (POS_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .bit_valid(bit_valid),
    .det      (det),
    .rpt_valid(rpt_valid),
    .rpt_ready(rpt_ready),
    .rpt_count(rpt_count),
    .rpt_first(rpt_first),
    .rpt_last (rpt_last),
    .rpt_none (rpt_none),
    .overrun  (overrun)
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
    ,.rpt_ts  (rpt_ts)
`endif
  );

  // Reference model: collects the frame's det bits, then derives the report from the whole frame.
  bit          m_run   = 1'b0;
  int          m_idx   = 0;
  bit          m_bits[FRAME_LEN];
  bit          m_valid = 1'b0;
  bit          m_ovr   = 1'b0;
  bit          m_none  = 1'b1;
  int          m_count = 0;
  int          m_first = 0;
  int          m_last  = 0;
  int unsigned m_cyc   = 0;
  int unsigned m_ts    = 0;

  always @(posedge clk) begin
    bit accept;
    bit closed;
    int n;
    int f;
    int l;
    if (!rst_n) begin
      m_run   = 1'b0;
      m_idx   = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_none  = 1'b1;
      m_count = 0;
      m_first = 0;
      m_last  = 0;
      m_ts    = 0;
      m_cyc   = 0;
      for (int i = 0; i < FRAME_LEN; i++) m_bits[i] = 1'b0;
    end else begin
      accept = m_valid && rpt_ready;
      closed = 1'b0;
      n = 0;
      f = -1;
      l = 0;
      if (!m_run) begin
        m_run = en;
        m_idx = 0;
      end else if (!en) begin
        m_run = 1'b0;
        m_idx = 0;
        for (int i = 0; i < FRAME_LEN; i++) m_bits[i] = 1'b0;
      end else if (bit_valid) begin
        m_bits[m_idx] = det;
        if (m_idx == FRAME_LEN - 1) begin
          for (int i = 0; i < FRAME_LEN; i++) begin
            if (m_bits[i]) begin
              n++;
              if (f < 0) f = i;
              l = i;
            end
            m_bits[i] = 1'b0;
          end
          closed = 1'b1;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
      if (closed) begin
        if (!m_valid || accept) begin
          m_valid = 1'b1;
          m_count = (n > CNT_MAX) ? CNT_MAX : n;
          m_first = (f < 0) ? 0 : f;
          m_last  = l;
          m_none  = (n == 0);
          m_ts    = m_cyc;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (accept) begin
        m_valid = 1'b0;
      end
      m_cyc++;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check_output("valid", 32'(rpt_valid), 32'(m_valid));
      check_output("overrun", 32'(overrun), 32'(m_ovr));
      if (m_valid) begin
        check_output("count", 32'(rpt_count), 32'(m_count));
        check_output("first", 32'(rpt_first), 32'(m_first));
        check_output("last", 32'(rpt_last), 32'(m_last));
        check_output("none", 32'(rpt_none), 32'(m_none));
`ifdef SEQ_MATCH_REPORTER_TIMESTAMP_EN
        check_output("ts", rpt_ts, m_ts);
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive bits from..to of pat; with gaps, a det=1 cycle without bit_valid follows each bit.
  task automatic apply_stimulus(input logic [15:0] pat, input int from, input int to, input bit gaps);
    for (int i = from; i <= to; i++) begin
      bit_valid = 1'b1;
      det       = pat[i];
      tick();
      if (gaps) begin
        bit_valid = 1'b0;
        det       = 1'b1;
        tick();
      end
    end
    bit_valid = 1'b0;
    det       = 1'b0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b1;
    bit_valid = 1'b1;
    det       = 1'b1;
    repeat (3) begin
      tick();
      cmp_on = 1'b1;
    end
    check_output("rst_valid", 32'(rpt_valid), 32'd0);
    check_output("rst_overrun", 32'(overrun), 32'd0);
    check_output("rst_none", 32'(rpt_none), 32'd1);
    check_output("rst_count", 32'(rpt_count), 32'd0);
    rst_n     = 1'b1;
    bit_valid = 1'b0;
    det       = 1'b0;
    tick();
  endtask

  task automatic drain();
    rpt_ready = 1'b1;
    tick();
    rpt_ready = 1'b0;
  endtask

  task automatic check_report(input string name, input int cnt, input int first, input int last, input bit none);
    check_output({name, "_valid"}, 32'(rpt_valid), 32'd1);
    check_output({name, "_count"}, 32'(rpt_count), 32'(cnt));
    check_output({name, "_first"}, 32'(rpt_first), 32'(first));
    check_output({name, "_last"}, 32'(rpt_last), 32'(last));
    check_output({name, "_none"}, 32'(rpt_none), 32'(none));
  endtask

  initial begin
    do_reset();

    $display("[TB] basic frame with idle det pulses");
    apply_stimulus(16'h8088, 0, 14, 1'b1);
    check_output("basic_early", 32'(rpt_valid), 32'd0);
    apply_stimulus(16'h8088, 15, 15, 1'b0);
    check_report("basic", 3, 3, 15, 1'b0);
    drain();
    check_output("basic_drop", 32'(rpt_valid), 32'd0);

    $display("[TB] saturation then empty frame");
    apply_stimulus(16'hFFFF, 0, 15, 1'b0);
    check_report("sat", 15, 0, 15, 1'b0);
    drain();
    apply_stimulus(16'h0000, 0, 15, 1'b0);
    check_report("empty", 0, 0, 0, 1'b1);
    drain();

    $display("[TB] backpressure and overrun");
    apply_stimulus(16'h0012, 0, 15, 1'b0);
    apply_stimulus(16'h0100, 0, 15, 1'b0);
    check_report("held", 2, 1, 4, 1'b0);
    check_output("ovr_set", 32'(overrun), 32'd1);
    drain();
    check_output("ovr_drop", 32'(rpt_valid), 32'd0);
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check_output("ovr_sticky", 32'(overrun), 32'd1);

    $display("[TB] close and accept in the same cycle");
    do_reset();
    apply_stimulus(16'h0006, 0, 15, 1'b0);
    check_report("pend", 2, 1, 2, 1'b0);
    apply_stimulus(16'h4000, 0, 14, 1'b0);
    rpt_ready = 1'b1;
    apply_stimulus(16'h4000, 15, 15, 1'b0);
    rpt_ready = 1'b0;
    check_report("swap", 1, 14, 14, 1'b0);
    check_output("swap_ovr", 32'(overrun), 32'd0);
    drain();

    $display("[TB] en drop mid-frame");
    apply_stimulus(16'h0010, 0, 8, 1'b0);
    en = 1'b0;
    tick();
    tick();
    check_output("endrop_valid", 32'(rpt_valid), 32'd0);
    en = 1'b1;
    tick();
    apply_stimulus(16'h8001, 0, 15, 1'b0);
    check_report("fresh", 2, 0, 15, 1'b0);

    $display("[TB] reset with report pending and partial frame");
    apply_stimulus(16'h0004, 0, 5, 1'b0);
    do_reset();
    apply_stimulus(16'h0020, 0, 15, 1'b0);
    check_report("postrst", 1, 5, 5, 1'b0);
    drain();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
